// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and AXI constants for the SRAM-like to AXI3 bridge.
// Both SRAM ports are turned into single-beat AXI transfers.
package sram_axi_bridge_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    localparam logic [7:0]      AXI_LEN_SINGLE = 8'd0;
    localparam logic [1:0]      AXI_BURST_INCR = 2'b01;
    localparam logic [ID_W-1:0] ID_INST        = 4'd0;
    localparam logic [ID_W-1:0] ID_DATA        = 4'd1;
    localparam logic [ID_W-1:0] ID_WRITE       = 4'd1;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_SEND = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    // SRAM size codes map directly onto AXI byte-count exponents.
    function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
        return {1'b0, sram_size};
    endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// AXI3 master/slave signal bundle used by the bridge.
interface sram_axi_bridge_if;
    import sram_axi_bridge_pkg::*;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [1:0]        awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;

    logic [ID_W-1:0]   wid;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/sram_axi_bridge.sv
// Bridges an inst-side and a data-side SRAM-like port onto one AXI3 master.
// One read outstanding at a time; data writes run on an independent FSM.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
(
    input  logic        aclk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    input  logic        preIF_cancel,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    sram_axi_bridge_if.master axi
);

    r_state_e    r_state_q, r_state_d;
    logic [31:0] raddr_q, raddr_d;
    logic [1:0]  rsize_q, rsize_d;
    logic        rsel_data_q, rsel_data_d;
    logic        cancel_q, cancel_d;
    logic        inst_ok_q, inst_ok_d;
    logic        data_ok_q, data_ok_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;

    w_state_e    w_state_q, w_state_d;
    logic [31:0] waddr_q, waddr_d;
    logic [1:0]  wsize_q, wsize_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;

    logic data_rd_req, data_wr_req, data_rd_busy;
    logic data_rd_acc, inst_rd_acc, wr_acc, b_done;

    assign data_rd_req  = data_sram_req & ~data_sram_wr;
    assign data_wr_req  = data_sram_req & data_sram_wr;
    assign data_rd_busy = (r_state_q != R_IDLE) & rsel_data_q;

    // Data reads wait for the write path to drain so a read never passes a write.
    assign data_rd_acc = ~reset & (r_state_q == R_IDLE) & data_rd_req & (w_state_q == W_IDLE);
    assign inst_rd_acc = ~reset & (r_state_q == R_IDLE) & inst_sram_req & ~data_rd_acc;
    assign wr_acc      = ~reset & (w_state_q == W_IDLE) & data_wr_req & ~data_rd_busy;
    assign b_done      = (w_state_q == W_RESP) & axi.bvalid;

    assign inst_sram_addr_ok = inst_rd_acc;
    assign data_sram_addr_ok = data_rd_acc | wr_acc;
    assign inst_sram_data_ok = ~reset & inst_ok_q;
    assign data_sram_data_ok = ~reset & data_ok_q;
    assign inst_sram_rdata   = inst_rdata_q;
    assign data_sram_rdata   = data_rdata_q;

    always_comb begin
        r_state_d    = r_state_q;
        raddr_d      = raddr_q;
        rsize_d      = rsize_q;
        rsel_data_d  = rsel_data_q;
        cancel_d     = cancel_q;
        inst_ok_d    = 1'b0;
        data_ok_d    = b_done;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (data_rd_acc) begin
                    raddr_d     = data_sram_addr;
                    rsize_d     = data_sram_size;
                    rsel_data_d = 1'b1;
                    r_state_d   = R_ADDR;
                end else if (inst_rd_acc) begin
                    raddr_d     = inst_sram_addr;
                    rsize_d     = inst_sram_size;
                    rsel_data_d = 1'b0;
                    cancel_d    = 1'b0;
                    r_state_d   = R_ADDR;
                end
            end
            R_ADDR: begin
                if (preIF_cancel && !rsel_data_q) cancel_d = 1'b1;
                if (axi.arready) r_state_d = R_DATA;
            end
            R_DATA: begin
                if (axi.rvalid) begin
                    r_state_d = R_IDLE;
                    cancel_d  = 1'b0;
                    if (rsel_data_q) begin
                        data_rdata_d = axi.rdata;
                        data_ok_d    = 1'b1;
                    end else if (!(cancel_q || preIF_cancel)) begin
                        // A cancelled fetch still drains its beat but is never delivered.
                        inst_rdata_d = axi.rdata;
                        inst_ok_d    = 1'b1;
                    end
                end else if (preIF_cancel && !rsel_data_q) begin
                    cancel_d = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wsize_d   = wsize_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        case (w_state_q)
            W_IDLE: begin
                if (wr_acc) begin
                    waddr_d   = data_sram_addr;
                    wsize_d   = data_sram_size;
                    wdata_d   = data_sram_wdata;
                    wstrb_d   = data_sram_wstrb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    w_state_d = W_SEND;
                end
            end
            W_SEND: begin
                if (axi.awready) awvalid_d = 1'b0;
                if (axi.wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) w_state_d = W_RESP;
            end
            W_RESP: begin
                if (axi.bvalid) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state_q    <= R_IDLE;
            raddr_q      <= '0;
            rsize_q      <= '0;
            rsel_data_q  <= 1'b0;
            cancel_q     <= 1'b0;
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            w_state_q    <= W_IDLE;
            waddr_q      <= '0;
            wsize_q      <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
        end else begin
            r_state_q    <= r_state_d;
            raddr_q      <= raddr_d;
            rsize_q      <= rsize_d;
            rsel_data_q  <= rsel_data_d;
            cancel_q     <= cancel_d;
            inst_ok_q    <= inst_ok_d;
            data_ok_q    <= data_ok_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            w_state_q    <= w_state_d;
            waddr_q      <= waddr_d;
            wsize_q      <= wsize_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
        end
    end

    assign axi.arid    = rsel_data_q ? ID_DATA : ID_INST;
    assign axi.araddr  = raddr_q;
    assign axi.arlen   = AXI_LEN_SINGLE;
    assign axi.arsize  = axi_size(rsize_q);
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = ~reset & (r_state_q == R_ADDR);
    assign axi.rready  = ~reset & (r_state_q == R_DATA);

    assign axi.awid    = ID_WRITE;
    assign axi.awaddr  = waddr_q;
    assign axi.awlen   = AXI_LEN_SINGLE;
    assign axi.awsize  = axi_size(wsize_q);
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'b0000;
    assign axi.awprot  = 3'b000;
    assign axi.awvalid = ~reset & awvalid_q;
    assign axi.wid     = ID_WRITE;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = ~reset & wvalid_q;
    assign axi.bready  = ~reset & (w_state_q == W_RESP);

    // Response ids/status and the inst-side write fields carry no routing information.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                             axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with a data_ok scoreboard.
module tb_sram_axi_bridge;

    logic        aclk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr, preIF_cancel;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic [3:0]  inst_sram_wstrb;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [3:0]  data_sram_wstrb;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    sram_axi_bridge_if axi();

    sram_axi_bridge dut (
        .aclk              (aclk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_wdata   (inst_sram_wdata),
        .preIF_cancel      (preIF_cancel),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .axi               (axi)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
    } exp_t;

    logic [31:0] inst_q[$];
    exp_t        data_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Slave side of one read: waits for AR, accepts it, returns one beat.
    task automatic serve_read(input logic [31:0] rd, input bit to_inst);
        int n = 0;
        while (!axi.arvalid && n < 20) begin
            step();
            n++;
        end
        check("ar_wait", axi.arvalid, 1);
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        check("rready", axi.rready, 1);
        if (to_inst) inst_q.push_back(rd);
        else         data_q.push_back(exp_t'{1'b1, rd});
        axi.rvalid = 1'b1;
        axi.rdata  = rd;
        step();
        axi.rvalid = 1'b0;
    endtask

    // Scoreboard: every data_ok pulse must match the oldest expected completion.
    always @(negedge aclk) begin
        if (!reset) begin
            if (inst_sram_data_ok) begin
                if (inst_q.size() == 0) check("inst_ok_unexpected", inst_sram_data_ok, 0);
                else begin
                    logic [31:0] e;
                    e = inst_q.pop_front();
                    check("inst_rdata_sb", inst_sram_rdata, e);
                    $display("inst data_ok rdata=%h", inst_sram_rdata);
                end
            end
            if (data_sram_data_ok) begin
                if (data_q.size() == 0) check("data_ok_unexpected", data_sram_data_ok, 0);
                else begin
                    exp_t e;
                    e = data_q.pop_front();
                    if (e.is_read) check("data_rdata_sb", data_sram_rdata, e.data);
                    $display("data data_ok read=%0d rdata=%h", e.is_read, data_sram_rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        inst_sram_req = 1'b1; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
        inst_sram_addr = 32'h0; inst_sram_wstrb = 4'h0; inst_sram_wdata = 32'h0;
        preIF_cancel = 1'b0;
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2;
        data_sram_addr = 32'h0; data_sram_wstrb = 4'h0; data_sram_wdata = 32'h0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'h0; axi.rid = 4'h0;
        axi.rresp = 2'b00; axi.rlast = 1'b1; axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bvalid = 1'b0; axi.bid = 4'h1; axi.bresp = 2'b00;

        // Reset behaviour with a request already asserted
        step(); step(); settle();
        check("rst_inst_addr_ok", inst_sram_addr_ok, 0);
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_bready", axi.bready, 0);
        reset = 1'b0;
        inst_sram_req = 1'b0;
        step();
        check("rst_inst_rdata", inst_sram_rdata, 0);
        check("rst_data_rdata", data_sram_rdata, 0);

        // Minimum-latency inst read
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000000; inst_sram_size = 2'd2;
        settle();
        check("t1_addr_ok_c0", inst_sram_addr_ok, 1);
        step();
        inst_sram_req = 1'b0;
        check("t1_arvalid_c1", axi.arvalid, 1);
        check("t1_araddr", axi.araddr, 32'h1C000000);
        check("t1_arid", axi.arid, 0);
        check("t1_arsize", axi.arsize, 3'd2);
        check("t1_arlen", axi.arlen, 0);
        check("t1_arburst", axi.arburst, 2'b01);
        check("t1_awid", axi.awid, 1);
        check("t1_wlast", axi.wlast, 1);
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        check("t1_rready_c2", axi.rready, 1);
        check("t1_arvalid_drop", axi.arvalid, 0);
        inst_q.push_back(32'h02800000);
        axi.rvalid = 1'b1; axi.rdata = 32'h02800000;
        step();
        axi.rvalid = 1'b0;
        check("t1_data_ok_c3", inst_sram_data_ok, 1);
        check("t1_rdata", inst_sram_rdata, 32'h02800000);
        step();
        check("t1_data_ok_pulse", inst_sram_data_ok, 0);

        // Data read beats a simultaneous inst read
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000040;
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h200;
        settle();
        check("t2_data_addr_ok", data_sram_addr_ok, 1);
        check("t2_inst_addr_ok", inst_sram_addr_ok, 0);
        step();
        data_sram_req = 1'b0;
        settle();
        check("t2_arid", axi.arid, 1);
        check("t2_araddr", axi.araddr, 32'h200);
        check("t2_inst_wait_addr", inst_sram_addr_ok, 0);
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        settle();
        check("t2_inst_wait_data", inst_sram_addr_ok, 0);
        data_q.push_back(exp_t'{1'b1, 32'hA5A50001});
        axi.rvalid = 1'b1; axi.rdata = 32'hA5A50001;
        step();
        axi.rvalid = 1'b0;
        settle();
        check("t2_data_ok", data_sram_data_ok, 1);
        check("t2_inst_addr_ok_after", inst_sram_addr_ok, 1);
        step();
        inst_sram_req = 1'b0;
        check("t2_inst_arid", axi.arid, 0);
        check("t2_inst_araddr", axi.araddr, 32'h1C000040);
        serve_read(32'h11112222, 1'b1);
        step();

        // Data write with AW accepted two cycles before W
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h100;
        data_sram_wdata = 32'hDEADBEEF; data_sram_wstrb = 4'hF; data_sram_size = 2'd2;
        settle();
        check("t3_addr_ok", data_sram_addr_ok, 1);
        step();
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_wdata = 32'h0; data_sram_wstrb = 4'h0;
        check("t3_awvalid", axi.awvalid, 1);
        check("t3_wvalid", axi.wvalid, 1);
        check("t3_awaddr", axi.awaddr, 32'h100);
        check("t3_awsize", axi.awsize, 3'd2);
        check("t3_wdata", axi.wdata, 32'hDEADBEEF);
        check("t3_wstrb", axi.wstrb, 4'hF);
        check("t3_wid", axi.wid, 1);
        axi.awready = 1'b1;
        step();
        axi.awready = 1'b0;
        check("t3_awvalid_drop", axi.awvalid, 0);
        check("t3_wvalid_hold1", axi.wvalid, 1);
        step();
        check("t3_wvalid_hold2", axi.wvalid, 1);
        check("t3_bready_early", axi.bready, 0);
        axi.wready = 1'b1;
        step();
        axi.wready = 1'b0;
        check("t3_wvalid_drop", axi.wvalid, 0);
        check("t3_bready", axi.bready, 1);

        // Read issued during W_RESP must wait for the write response
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h100;
        settle();
        check("t4_raw_block0", data_sram_addr_ok, 0);
        step();
        check("t4_raw_block1", data_sram_addr_ok, 0);
        check("t4_no_early_ok", data_sram_data_ok, 0);
        data_q.push_back(exp_t'{1'b0, 32'h0});
        axi.bvalid = 1'b1;
        step();
        axi.bvalid = 1'b0;
        settle();
        check("t4_wr_data_ok", data_sram_data_ok, 1);
        check("t4_rd_addr_ok", data_sram_addr_ok, 1);
        step();
        data_sram_req = 1'b0;
        check("t4_wr_ok_pulse", data_sram_data_ok, 0);
        check("t4_arid", axi.arid, 1);
        check("t4_araddr", axi.araddr, 32'h100);
        serve_read(32'hCAFEF00D, 1'b0);
        step();

        // Inst read and data write accepted together
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000100;
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h104;
        data_sram_wdata = 32'h12345678; data_sram_wstrb = 4'h3; data_sram_size = 2'd1;
        settle();
        check("t5_inst_addr_ok", inst_sram_addr_ok, 1);
        check("t5_data_addr_ok", data_sram_addr_ok, 1);
        step();
        inst_sram_req = 1'b0; data_sram_req = 1'b0; data_sram_wr = 1'b0;
        check("t5_arvalid", axi.arvalid, 1);
        check("t5_awvalid", axi.awvalid, 1);
        check("t5_awsize", axi.awsize, 3'd1);
        check("t5_wstrb", axi.wstrb, 4'h3);
        axi.arready = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
        step();
        axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
        inst_q.push_back(32'h0BADF00D);
        data_q.push_back(exp_t'{1'b0, 32'h0});
        axi.rvalid = 1'b1; axi.rdata = 32'h0BADF00D; axi.bvalid = 1'b1;
        step();
        axi.rvalid = 1'b0; axi.bvalid = 1'b0;
        check("t5_inst_data_ok", inst_sram_data_ok, 1);
        check("t5_data_data_ok", data_sram_data_ok, 1);
        step();

        // Cancel during R_DATA: beat drained, nothing delivered
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000200; inst_sram_size = 2'd2;
        settle();
        step();
        inst_sram_req = 1'b0;
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        preIF_cancel = 1'b1;
        settle();
        check("t6_rready_cancel", axi.rready, 1);
        step();
        preIF_cancel = 1'b0;
        check("t6_rready_hold", axi.rready, 1);
        axi.rvalid = 1'b1; axi.rdata = 32'hDEAD0000;
        step();
        axi.rvalid = 1'b0;
        check("t6_no_inst_ok", inst_sram_data_ok, 0);
        check("t6_rready_done", axi.rready, 0);
        step();
        check("t6_no_inst_ok2", inst_sram_data_ok, 0);

        // Cancel with nothing outstanding is harmless; next fetch returns normally
        preIF_cancel = 1'b1;
        step();
        preIF_cancel = 1'b0;
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000204;
        settle();
        check("t6_next_addr_ok", inst_sram_addr_ok, 1);
        step();
        inst_sram_req = 1'b0;
        check("t6_next_araddr", axi.araddr, 32'h1C000204);
        serve_read(32'h2A000204, 1'b1);
        check("t6_next_data_ok", inst_sram_data_ok, 1);
        step();

        // Reset while AR is pending abandons the read
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000300;
        settle();
        step();
        inst_sram_req = 1'b0;
        check("t7_arvalid_pre", axi.arvalid, 1);
        reset = 1'b1;
        settle();
        check("t7_arvalid_in_rst", axi.arvalid, 0);
        step();
        reset = 1'b0;
        check("t7_arvalid_after", axi.arvalid, 0);
        check("t7_rready_after", axi.rready, 0);
        check("t7_inst_rdata_clr", inst_sram_rdata, 0);
        check("t7_data_rdata_clr", data_sram_rdata, 0);
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        check("t7_still_idle", axi.rready, 0);
        step(); step();
        check("t7_no_inst_ok", inst_sram_data_ok, 0);

        check("sb_inst_empty", inst_q.size(), 0);
        check("sb_data_empty", data_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
